// File: rtl/fft_stage_feeder_pkg.sv
// Shared types and address helpers for the FFT stage feeder:
// FSM states and the butterfly pair / twiddle index mapping of one DIT stage.
package fft_stage_feeder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2
    } state_t;

    // Lower address of butterfly pair k: insert a zero at bit position 'stage'.
    function automatic int pairAddrA(input int k, input int stage);
        int h;
        h = 1 << stage;
        return ((k >> stage) << (stage + 1)) | (k & (h - 1));
    endfunction

    function automatic int twiddleIndex(input int k, input int stage, input int logN);
        return (k & ((1 << stage) - 1)) << (logN - 1 - stage);
    endfunction

endpackage

// File: rtl/fft_stage_feeder_if.sv
// Bundle of the feeder's sample input, twiddle ROM link and butterfly-facing outputs.
interface fft_stage_feeder_if #(
    parameter int WIDTH = fft_stage_feeder_pkg::DEFAULT_WIDTH,
    parameter int LOG_N = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_nd;
    logic [LOG_N-2:0] tw_addr;
    logic [WIDTH-1:0] tw_in;
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] xb;
    logic [WIDTH-1:0] w;
    logic [LOG_N-1:0] m_out;
    logic             x_nd;
    logic             error;

    modport master (
        input  in_data, in_nd, tw_in,
        output tw_addr, xa, xb, w, m_out, x_nd, error
    );

    modport slave (
        output in_data, in_nd, tw_in,
        input  tw_addr, xa, xb, w, m_out, x_nd, error
    );
endinterface

// File: rtl/fft_stage_feeder_pingpong_buffer.sv
// Two-bank frame buffer: one bank fills in natural order while the other is read.
// Tracks the write bank's full state and performs the bank swap on request.
module pingpong_buffer
    import fft_stage_feeder_pkg::*;
#(
    parameter int N     = 16,
    parameter int LOG_N = 4,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_swapReq,
    input  logic             i_re,
    input  logic [LOG_N-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_swap,
    output logic             o_drop
);
    logic             r_wbank;
    logic [LOG_N-1:0] r_wptr;
    logic             r_wfull;
    logic [WIDTH-1:0] r_mem [2*N];
    logic [WIDTH-1:0] r_rdata;
    logic             w_accept;
    logic             w_lastWrite;

    // A write completing the frame counts as full in the same cycle so the
    // swap needs no extra bubble.
    assign w_accept    = i_we & ~r_wfull;
    assign w_lastWrite = w_accept & (r_wptr == LOG_N'(N - 1));
    assign o_swap      = i_swapReq & (r_wfull | w_lastWrite);
    assign o_drop      = i_we & r_wfull;
    assign o_rdata     = r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wbank <= 1'b0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + LOG_N'(1);
            end
            if (o_swap) begin
                r_wbank <= ~r_wbank;
                r_wfull <= 1'b0;
            end else if (w_lastWrite) begin
                r_wfull <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{r_wbank, r_wptr}] <= i_wdata;
        end
    end

    // The read bank is always the one not being written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[{~r_wbank, i_raddr}];
        end
    end
endmodule

// File: rtl/fft_stage_feeder.sv
// Input stage of one radix-2 DIT FFT pass: buffers a frame and issues the N/2
// butterfly pairs of stage STAGE, one pair every two cycles.
module fft_stage_feeder
    import fft_stage_feeder_pkg::*;
#(
    parameter int N     = 16,
    parameter int LOG_N = 4,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STAGE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_stage_feeder_if.master bus
);
    state_t           r_state;
    state_t           w_nextState;
    logic [LOG_N-2:0] r_pair;
    logic [LOG_N-2:0] r_twAddr;
    logic [LOG_N-1:0] r_mOut;
    logic [WIDTH-1:0] r_xa;
    logic             r_xNd;
    logic             r_error;
    logic [LOG_N-1:0] w_addrA;
    logic [LOG_N-1:0] w_addrB;
    logic [LOG_N-1:0] w_rdAddr;
    logic [LOG_N-2:0] w_twIdx;
    logic [WIDTH-1:0] w_rdata;
    logic             w_lastPair;
    logic             w_swapReq;
    logic             w_swap;
    logic             w_drop;
    logic             w_readEn;

    assign w_addrA    = LOG_N'(pairAddrA(int'(r_pair), STAGE));
    assign w_addrB    = w_addrA + LOG_N'(1 << STAGE);
    assign w_twIdx    = (LOG_N-1)'(twiddleIndex(int'(r_pair), STAGE, LOG_N));
    assign w_lastPair = (r_pair == (LOG_N-1)'(N / 2 - 1));
    assign w_swapReq  = (r_state == IDLE) | ((r_state == READ_B) & w_lastPair);
    assign w_readEn   = (r_state != IDLE);

    pingpong_buffer #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH)) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (bus.in_nd),
        .i_wdata   (bus.in_data),
        .i_swapReq (w_swapReq),
        .i_re      (w_readEn),
        .i_raddr   (w_rdAddr),
        .o_rdata   (w_rdata),
        .o_swap    (w_swap),
        .o_drop    (w_drop)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_rdAddr    = w_addrA;
        case (r_state)
            IDLE:    w_nextState = w_swap ? READ_A : IDLE;
            READ_A:  w_nextState = READ_B;
            READ_B: begin
                w_rdAddr    = w_addrB;
                w_nextState = (!w_lastPair || w_swap) ? READ_A : IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Twiddle address leads by one cycle so the registered ROM data lines up with x_nd.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pair   <= '0;
            r_twAddr <= '0;
            r_mOut   <= '0;
            r_xa     <= '0;
            r_xNd    <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_xNd <= (r_state == READ_B);
            if (w_drop) begin
                r_error <= 1'b1;
            end
            if (r_state == READ_A) begin
                r_twAddr <= w_twIdx;
            end
            if (r_state == READ_B) begin
                r_xa   <= w_rdata;
                r_mOut <= w_addrA;
                r_pair <= r_pair + (LOG_N-1)'(1);
            end
        end
    end

    assign bus.tw_addr = r_twAddr;
    assign bus.xa      = r_xa;
    assign bus.xb      = w_rdata;
    assign bus.w       = bus.tw_in;
    assign bus.m_out   = r_mOut;
    assign bus.x_nd    = r_xNd;
    assign bus.error   = r_error;
endmodule

// File: tb/tb_fft_stage_feeder.sv
// Bench for fft_stage_feeder: three DUTs (stages 0..2, N=8) share one input stream
// and are compared every cycle against a frame-level timing/address model.
module tb_fft_stage_feeder;
    localparam int N     = 8;
    localparam int LOG_N = 3;
    localparam int WIDTH = 32;
    localparam int NS    = 3;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] xa;
        logic [WIDTH-1:0] xb;
        logic [WIDTH-1:0] w;
        int               m;
        int               tw;
    } pair_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             inNd = 1'b0;
    logic [WIDTH-1:0] inData = '0;
    logic             checkEn = 1'b0;
    int               cyc = 0;
    int               total = 0;
    int               bad = 0;

    logic [WIDTH-1:0] twRom [N/2];
    logic [WIDTH-1:0] twIn [NS];
    logic             xNd [NS];
    logic             errO [NS];
    logic [WIDTH-1:0] xaO [NS];
    logic [WIDTH-1:0] xbO [NS];
    logic [WIDTH-1:0] wO [NS];
    logic [LOG_N-1:0] mO [NS];
    logic [LOG_N-2:0] twA [NS];

    pair_t            expQ [NS][$];
    pair_t            logQ [NS][$];
    logic [WIDTH-1:0] frame [N];
    int               wCount;
    int               lastStart;
    int               errCycle;

    int litA  [NS][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int litB  [NS][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int litTw [NS][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_stage_feeder_if #(.WIDTH(WIDTH), .LOG_N(LOG_N)) bus0 ();
    fft_stage_feeder_if #(.WIDTH(WIDTH), .LOG_N(LOG_N)) bus1 ();
    fft_stage_feeder_if #(.WIDTH(WIDTH), .LOG_N(LOG_N)) bus2 ();

    fft_stage_feeder #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH), .STAGE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    fft_stage_feeder #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH), .STAGE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fft_stage_feeder #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH), .STAGE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.in_data = inData;
    assign bus1.in_data = inData;
    assign bus2.in_data = inData;
    assign bus0.in_nd = inNd;
    assign bus1.in_nd = inNd;
    assign bus2.in_nd = inNd;
    assign bus0.tw_in = twIn[0];
    assign bus1.tw_in = twIn[1];
    assign bus2.tw_in = twIn[2];

    assign xNd[0] = bus0.x_nd;    assign xNd[1] = bus1.x_nd;    assign xNd[2] = bus2.x_nd;
    assign errO[0] = bus0.error;  assign errO[1] = bus1.error;  assign errO[2] = bus2.error;
    assign xaO[0] = bus0.xa;      assign xaO[1] = bus1.xa;      assign xaO[2] = bus2.xa;
    assign xbO[0] = bus0.xb;      assign xbO[1] = bus1.xb;      assign xbO[2] = bus2.xb;
    assign wO[0] = bus0.w;        assign wO[1] = bus1.w;        assign wO[2] = bus2.w;
    assign mO[0] = bus0.m_out;    assign mO[1] = bus1.m_out;    assign mO[2] = bus2.m_out;
    assign twA[0] = bus0.tw_addr; assign twA[1] = bus1.tw_addr; assign twA[2] = bus2.tw_addr;

    // Registered twiddle ROM, one read port per DUT.
    always @(posedge clk) begin
        for (int s = 0; s < NS; s++) twIn[s] <= twRom[twA[s]];
    end

    task automatic checkOutput(input string name, input int s, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s stage%0d cycle%0d: got %0h, expected %0h", name, s, cyc, act, req);
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < NS; s++) expQ[s].delete();
        wCount    = 0;
        lastStart = -1000000;
        errCycle  = -1;
    endtask

    // A finished frame starts reading the cycle after its last write, or as soon as the
    // previous frame's N read cycles end; writes before that start are dropped.
    task automatic modelWrite(input logic [WIDTH-1:0] d, input int c);
        int    start;
        int    k;
        int    h;
        pair_t e;
        if (c < lastStart) begin
            if (errCycle < 0) errCycle = c + 1;
            return;
        end
        frame[wCount] = d;
        wCount++;
        if (wCount < N) return;
        wCount    = 0;
        start     = (c + 1 > lastStart + N) ? c + 1 : lastStart + N;
        lastStart = start;
        for (int s = 0; s < NS; s++) begin
            h = 1 << s;
            k = 0;
            for (int a = 0; a < N; a++) begin
                if (((a >> s) & 1) == 0) begin
                    e.cyc = start + 2 * k + 2;
                    e.xa  = frame[a];
                    e.xb  = frame[a + h];
                    e.m   = a;
                    e.tw  = (a % h) * (N / (2 * h));
                    e.w   = twRom[e.tw];
                    expQ[s].push_back(e);
                    k++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        pair_t e;
        pair_t l;
        if (checkEn) begin
            for (int s = 0; s < NS; s++) begin
                if (xNd[s]) begin
                    l.cyc = cyc;
                    l.xa  = xaO[s];
                    l.xb  = xbO[s];
                    l.w   = wO[s];
                    l.m   = int'(mO[s]);
                    l.tw  = int'(twA[s]);
                    logQ[s].push_back(l);
                end
                if (expQ[s].size() > 0 && expQ[s][0].cyc == cyc) begin
                    e = expQ[s].pop_front();
                    checkOutput("x_nd", s, xNd[s], 1);
                    checkOutput("xa", s, xaO[s], e.xa);
                    checkOutput("xb", s, xbO[s], e.xb);
                    checkOutput("w", s, wO[s], e.w);
                    checkOutput("m_out", s, mO[s], e.m);
                    checkOutput("tw_addr", s, twA[s], e.tw);
                end else begin
                    checkOutput("x_nd_idle", s, xNd[s], 0);
                end
                checkOutput("error", s, errO[s], (errCycle >= 0 && cyc >= errCycle));
            end
        end
    end

    task automatic applyStimulus(input logic nd, input logic [WIDTH-1:0] d);
        inNd   = nd;
        inData = d;
        if (nd) modelWrite(d, cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        inNd  = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        rst_n = 1'b1;
    endtask

    task automatic clearLogs();
        for (int s = 0; s < NS; s++) logQ[s].delete();
    endtask

    // Stage-0 pulses of frames with sample i = {i,16'd0}: xa.re = 2j, xb.re = 2j+1, 2 cycles apart.
    task automatic checkRampStage0(input string name, input int count);
        checkOutput({name, "_count"}, 0, logQ[0].size(), count);
        for (int j = 0; j < logQ[0].size() && j < count; j++) begin
            checkOutput({name, "_xa"}, 0, 32'(logQ[0][j].xa[31:16]), 2 * j);
            checkOutput({name, "_xb"}, 0, 32'(logQ[0][j].xb[31:16]), 2 * j + 1);
            if (j > 0) checkOutput({name, "_gap"}, 0, logQ[0][j].cyc - logQ[0][j-1].cyc, 2);
        end
    endtask

    initial begin
        int tLast;
        for (int i = 0; i < N / 2; i++) twRom[i] = $urandom;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++) begin
            checkOutput("rst_x_nd", s, xNd[s], 0);
            checkOutput("rst_xa", s, xaO[s], 0);
            checkOutput("rst_xb", s, xbO[s], 0);
            checkOutput("rst_m_out", s, mO[s], 0);
            checkOutput("rst_tw_addr", s, twA[s], 0);
            checkOutput("rst_error", s, errO[s], 0);
        end
        rst_n   = 1'b1;
        checkEn = 1'b1;
        idle(2);

        clearLogs();
        tLast = 0;
        for (int i = 0; i < N; i++) begin
            tLast = cyc;
            applyStimulus(1'b1, WIDTH'(i) << 16);
        end
        idle(12);
        for (int s = 0; s < NS; s++) begin
            checkOutput("lit_count", s, logQ[s].size(), 4);
            if (logQ[s].size() > 0) checkOutput("lit_latency", s, logQ[s][0].cyc - tLast, 3);
            for (int j = 0; j < logQ[s].size() && j < 4; j++) begin
                checkOutput("lit_m", s, logQ[s][j].m, litA[s][j]);
                checkOutput("lit_xa", s, 32'(logQ[s][j].xa[31:16]), litA[s][j]);
                checkOutput("lit_xb", s, 32'(logQ[s][j].xb[31:16]), litB[s][j]);
                checkOutput("lit_tw", s, logQ[s][j].tw, litTw[s][j]);
                if (j > 0) checkOutput("lit_gap", s, logQ[s][j].cyc - logQ[s][j-1].cyc, 2);
            end
        end

        clearLogs();
        for (int i = 0; i < 2 * N; i++) applyStimulus(1'b1, WIDTH'(i) << 16);
        idle(20);
        checkRampStage0("b2b", 8);
        checkOutput("b2b_error", 0, errO[0], 0);

        clearLogs();
        for (int i = 0; i < 3 * N; i++) applyStimulus(1'b1, $urandom);
        idle(20);
        for (int s = 0; s < NS; s++) begin
            checkOutput("three_count", s, logQ[s].size(), 12);
            for (int j = 1; j < logQ[s].size(); j++)
                checkOutput("three_gap", s, logQ[s][j].cyc - logQ[s][j-1].cyc, 2);
        end

        clearLogs();
        for (int i = 0; i < N + 5; i++) applyStimulus(1'b1, $urandom);
        resetPulse();
        idle(12);
        checkOutput("pre_rst_pulses", 0, logQ[0].size(), 2);
        clearLogs();
        for (int i = 0; i < N; i++) applyStimulus(1'b1, WIDTH'(i) << 16);
        idle(12);
        checkRampStage0("post_rst", 4);
        checkOutput("post_rst_error", 0, errO[0], 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 199) == 0) resetPulse();
            else applyStimulus($urandom_range(0, 3) != 0, $urandom);
        end
        idle(N + 8);
        for (int s = 0; s < NS; s++) checkOutput("drain", s, expQ[s].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
